dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_SIZE, default 128, SHALL give the byte size of the attached dmem; addresses >= MEM_SIZE are out of range.
REQ-002 clk  input  1  single clock; every register SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 mN_req  input  1  (N=0,1) SHALL signal an access request from requester N.
REQ-005 mN_we  input  1  SHALL select store when 1 and load when 0.
REQ-006 mN_size  input  2  SHALL encode 00 byte, 01 half, 10 word; 11 is reserved.
REQ-007 mN_unsigned  input  1  SHALL select zero-extension (1) or sign-extension (0) for loads.
REQ-008 mN_addr  input  32  SHALL carry the byte address.
REQ-009 mN_wdata  input  32  SHALL carry store data, right-aligned.
REQ-010 mN_gnt  output  1  SHALL pulse for the single cycle in which the request is accepted.
REQ-011 mN_rvalid  output  1  SHALL be a one-cycle response strobe.
REQ-012 mN_rdata  output  32  SHALL carry extended load data, valid with rvalid.
REQ-013 mN_err  output  1  SHALL flag a rejected access, valid with rvalid.
REQ-014 daddr  output  32, dwdata  output  32, we  output  4, drdata  input  32 SHALL form the dmem port (combinational read, posedge write, word-aligned lanes).

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and RESP, with transitions IDLE->ACCESS on any req, ACCESS->RESP unconditionally and RESP->IDLE unconditionally.
REQ-016 In IDLE, gnt SHALL be combinational: the winner's gnt is high in the cycle where its req is high and the FSM is in IDLE.
REQ-017 When both reqs are high, the port named by the priority pointer SHALL win; the pointer SHALL move to the other port after every grant.
REQ-018 On the grant edge, the winner's addr, wdata, we, size, unsigned and id SHALL be captured; after this the requester may drop or change its inputs.
REQ-019 A requester SHALL hold req and all fields stable until gnt; the loser SHALL stay pending with no gnt.
REQ-020 In ACCESS, daddr SHALL equal {captured addr[31:2], 2'b00}.
REQ-021 In ACCESS, a legal store SHALL drive we as follows: byte 4'b0001<<addr[1:0]; half 4'b0011 (addr[1]=0) or 4'b1100; word 4'b1111.
REQ-022 For a legal store, dwdata SHALL carry the byte replicated x4, the half replicated x2, or the word unchanged.
REQ-023 we SHALL be 4'b0000 in every state other than ACCESS and for every illegal access.
REQ-024 In ACCESS, a load SHALL register the selected byte or half from drdata, extended per unsigned, or the full word.
REQ-025 An access SHALL be illegal when any of these holds: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr+bytes > MEM_SIZE.
REQ-026 An illegal access SHALL not write, SHALL return rdata=0 and SHALL set err=1 with rvalid.
REQ-027 In RESP, rvalid SHALL be high for the granted id only, for exactly one cycle; a store SHALL also produce rvalid with rdata=0.
REQ-028 Latency: a grant in cycle T SHALL give the write edge at the end of T+1 and rvalid in T+2; a new grant is possible no earlier than T+3.
REQ-029 When outside RESP, rvalid, err and rdata SHALL be 0.

Reset
REQ-030 While rst_n is low: state=IDLE, priority pointer=m0, all captured registers=0, gnt=rvalid=err=0, rdata=0, we=0, daddr=0, dwdata=0.
REQ-031 A reset asserted during ACCESS or RESP SHALL abort the access: no write edge reaches dmem and no rvalid is issued.

Structure
REQ-032 Package dmem_arb_pkg SHALL hold the size encodings (SZ_B, SZ_H, SZ_W), the FSM state typedef and the requester-id type.
REQ-033 Lane generation, store replication and load extraction/extension SHALL sit in one combinational sub-module, lsu_align.

Verification
REQ-034 m0 stores word 0xDEADBEEF at 0x10, then loads word from 0x10 -> we=1111 at T+1; rvalid in T+2; rdata=0xDEADBEEF, err=0.
REQ-035 m1 stores byte 0x80 at 0x13, then loads byte from 0x13 signed and unsigned -> we=1000, dwdata=0x80808080; rdata=0xFFFFFF80, then 0x00000080.
REQ-036 m0 and m1 both req continuously after reset -> grants alternate m0, m1, m0, m1, one every 3 cycles; no grant is lost.
REQ-037 Word store at 0x06, half store at 0x21, word load at 0x7E (MEM_SIZE=128) -> each returns err=1 and rdata=0; we stays 0000 throughout.
REQ-038 rst_n pulsed low in ACCESS of a word store to 0x20 -> memory at 0x20 is unchanged, no rvalid, state is IDLE and pointer is m0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types for the two-port data-memory arbiter.
//   - access size encodings (SZ_B/SZ_H/SZ_W, SZ_RSV reserved)
//   - FSM state enum, requester-id type, captured-request payload struct
//   - access_legal(): alignment and range check for one access
package dmem_arb_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // 0 = m0, 1 = m1
  typedef logic id_t;

  typedef struct packed {
    logic            we;
    logic [1:0]      size;
    logic            uns;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } req_t;

  // Illegal: reserved size, misaligned half/word, or any byte past mem_size.
  function automatic logic access_legal(input logic [1:0]      size,
                                        input logic [XLEN-1:0] addr,
                                        input logic [XLEN:0]   mem_size);
    logic [XLEN:0] nbytes;
    logic          ok;
    ok     = 1'b1;
    nbytes = '0;
    case (size)
      SZ_B:    nbytes = (XLEN+1)'(1);
      SZ_H:    nbytes = (XLEN+1)'(2);
      SZ_W:    nbytes = (XLEN+1)'(4);
      default: ok = 1'b0;
    endcase
    if ((size == SZ_H) && addr[0])             ok = 1'b0;
    if ((size == SZ_W) && (addr[1:0] != 2'b00)) ok = 1'b0;
    // 33-bit sum so addresses near 2^32 cannot wrap into range
    if (({1'b0, addr} + nbytes) > mem_size)     ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's handshake/bus bundle.
//   master: requester side (drives req/we/size/uns/addr/wdata)
//   slave : arbiter side   (drives gnt/rvalid/rdata/err)
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, size, uns, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, size, uns, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for one access.
//   size_i/addr_lo_i/uns_i : access shape
//   wdata_i  -> wdata_o    : right-aligned store data replicated across lanes
//   lanes_o                : byte write enables (0 for reserved size)
//   drdata_i -> rdata_o    : selected byte/half/word, zero- or sign-extended
module lsu_align
  import dmem_arb_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] drdata_i,
  output logic [3:0]  lanes_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Lane select from the word read back
  always_comb begin
    byte_c = 8'h00;
    case (addr_lo_i)
      2'd0:    byte_c = drdata_i[7:0];
      2'd1:    byte_c = drdata_i[15:8];
      2'd2:    byte_c = drdata_i[23:16];
      default: byte_c = drdata_i[31:24];
    endcase
    half_c = addr_lo_i[1] ? drdata_i[31:16] : drdata_i[15:0];
  end

  always_comb begin
    lanes_o = 4'b0000;
    wdata_o = '0;
    rdata_o = '0;
    case (size_i)
      SZ_B: begin
        lanes_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = uns_i ? {24'h0, byte_c} : {{24{byte_c[7]}}, byte_c};
      end
      SZ_H: begin
        lanes_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = uns_i ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
      end
      SZ_W: begin
        lanes_o = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = drdata_i;
      end
      default: begin
        lanes_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two requesters sharing one single-port data memory.
//   clk, rst_n          : clock, asynchronous active-low reset
//   m0, m1              : requester bundles (dmem_arbiter_if.slave)
//   daddr_o, dwdata_o   : word-aligned dmem address and lane-replicated data
//   we_o                : byte write enables, only in ACCESS for legal stores
//   drdata_i            : combinational dmem read data
// One access per three cycles: IDLE (grant) -> ACCESS (dmem) -> RESP (rvalid).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_arbiter_if.slave   m0,
  dmem_arbiter_if.slave   m1,
  output logic [31:0]     daddr_o,
  output logic [31:0]     dwdata_o,
  output logic [3:0]      we_o,
  input  logic [31:0]     drdata_i
);

  state_e      state_q, state_d;
  id_t         ptr_q, ptr_d;
  id_t         id_q, id_d;
  req_t        cap_q, cap_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  id_t         winner_c;
  logic        any_req_c;
  logic        grant_c;
  req_t        m0_req_c, m1_req_c, win_req_c;
  logic        legal_c;
  logic [3:0]  lanes_c;
  logic [31:0] st_data_c;
  logic [31:0] ld_data_c;

  // Arbitration: a lone requester wins, a tie goes to the pointer
  always_comb begin
    any_req_c = m0.req | m1.req;
    winner_c  = ptr_q;
    if (m0.req && !m1.req) winner_c = 1'b0;
    if (m1.req && !m0.req) winner_c = 1'b1;
    grant_c   = (state_q == ST_IDLE) && any_req_c;
    m0_req_c  = {m0.we, m0.size, m0.uns, m0.addr, m0.wdata};
    m1_req_c  = {m1.we, m1.size, m1.uns, m1.addr, m1.wdata};
    win_req_c = winner_c ? m1_req_c : m0_req_c;
  end

  assign m0.gnt = grant_c && (winner_c == 1'b0);
  assign m1.gnt = grant_c && (winner_c == 1'b1);

  assign legal_c = access_legal(cap_q.size, cap_q.addr, (XLEN+1)'(MEM_SIZE));

  lsu_align u_lsu_align (
    .size_i    (cap_q.size),
    .addr_lo_i (cap_q.addr[1:0]),
    .uns_i     (cap_q.uns),
    .wdata_i   (cap_q.wdata),
    .drdata_i  (drdata_i),
    .lanes_o   (lanes_c),
    .wdata_o   (st_data_c),
    .rdata_o   (ld_data_c)
  );

  // dmem port is live only during ACCESS; illegal accesses never write
  always_comb begin
    daddr_o  = '0;
    dwdata_o = '0;
    we_o     = 4'b0000;
    if (state_q == ST_ACCESS) begin
      daddr_o = {cap_q.addr[31:2], 2'b00};
      if (legal_c && cap_q.we) begin
        we_o     = lanes_c;
        dwdata_o = st_data_c;
      end
    end
  end

  // Next-state and response computation
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    cap_d    = cap_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_req_c) begin
          state_d = ST_ACCESS;
          cap_d   = win_req_c;
          id_d    = winner_c;
          ptr_d   = ~winner_c;
        end
      end
      ST_ACCESS: begin
        state_d  = ST_RESP;
        rvalid_d = 1'b1;
        err_d    = ~legal_c;
        rdata_d  = (legal_c && !cap_q.we) ? ld_data_c : 32'h0;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 1'b0;
      id_q     <= 1'b0;
      cap_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      cap_q    <= cap_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Response is steered to the granted requester only
  assign m0.rvalid = rvalid_q && (id_q == 1'b0);
  assign m0.err    = err_q    && (id_q == 1'b0);
  assign m0.rdata  = (id_q == 1'b0) ? rdata_q : 32'h0;
  assign m1.rvalid = rvalid_q && (id_q == 1'b1);
  assign m1.err    = err_q    && (id_q == 1'b1);
  assign m1.rdata  = (id_q == 1'b1) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table plus hand-written arbitration
// and reset-abort sequences; a small byte-lane memory stands in for dmem.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  we;
  logic [31:0] drdata;

  dmem_arbiter_if m0_if ();
  dmem_arbiter_if m1_if ();

  dmem_arbiter #(.MEM_SIZE(128)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0       (m0_if),
    .m1       (m1_if),
    .daddr_o  (daddr),
    .dwdata_o (dwdata),
    .we_o     (we),
    .drdata_i (drdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [32];
  assign drdata = (daddr[31:7] == 25'h0) ? mem[daddr[6:2]] : 32'h0;
  always @(posedge clk) begin
    if (daddr[31:7] == 25'h0)
      for (int b = 0; b < 4; b++)
        if (we[b]) mem[daddr[6:2]][8*b +: 8] <= dwdata[8*b +: 8];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_we;
    logic [31:0] exp_dw;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic p, input logic w, input logic [1:0] s,
                              input logic u, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] ewe, input logic [31:0] edw,
                              input logic [31:0] erd, input logic eerr);
    vec_t v;
    v.port = p; v.we = w; v.size = s; v.uns = u; v.addr = a; v.wdata = wd;
    v.exp_we = ewe; v.exp_dw = edw; v.exp_rd = erd; v.exp_err = eerr;
    return v;
  endfunction

  task automatic idle_inputs();
    m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.size = SZ_B; m0_if.uns = 1'b0;
    m0_if.addr = 32'h0; m0_if.wdata = 32'h0;
    m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.size = SZ_B; m1_if.uns = 1'b0;
    m1_if.addr = 32'h0; m1_if.wdata = 32'h0;
  endtask

  task automatic drive_port(input logic p, input logic r, input logic w, input logic [1:0] s,
                            input logic u, input logic [31:0] a, input logic [31:0] wd);
    if (p) begin
      m1_if.req = r; m1_if.we = w; m1_if.size = s; m1_if.uns = u; m1_if.addr = a; m1_if.wdata = wd;
    end else begin
      m0_if.req = r; m0_if.we = w; m0_if.size = s; m0_if.uns = u; m0_if.addr = a; m0_if.wdata = wd;
    end
  endtask

  // One transaction: request, grant, ACCESS checks, RESP checks, back to IDLE
  task automatic run_vec(input int idx, input vec_t v);
    logic granted;
    logic g;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    drive_port(v.port, 1'b1, v.we, v.size, v.uns, v.addr, v.wdata);
    granted = 1'b0;
    for (int w = 0; w < 8 && !granted; w++) begin
      #1;
      g = v.port ? m1_if.gnt : m0_if.gnt;
      if (g) granted = 1'b1;
      else @(negedge clk);
    end
    chk({tag, " gnt"}, 32'(granted), 32'd1);
    chk({tag, " other gnt"}, 32'(v.port ? m0_if.gnt : m1_if.gnt), 32'd0);
    if (!granted) begin
      idle_inputs();
      return;
    end
    @(posedge clk); #1;
    // requester drops and scrambles its fields right after the grant
    drive_port(v.port, 1'b0, ~v.we, SZ_W, ~v.uns, 32'hFFFF_FFFC, 32'h5555_AAAA);
    chk({tag, " daddr"}, daddr, {v.addr[31:2], 2'b00});
    chk({tag, " we"}, 32'(we), 32'(v.exp_we));
    chk({tag, " dwdata"}, dwdata, v.exp_dw);
    @(posedge clk); #1;
    chk({tag, " rvalid"}, 32'(v.port ? m1_if.rvalid : m0_if.rvalid), 32'd1);
    chk({tag, " other rvalid"}, 32'(v.port ? m0_if.rvalid : m1_if.rvalid), 32'd0);
    chk({tag, " rdata"}, v.port ? m1_if.rdata : m0_if.rdata, v.exp_rd);
    chk({tag, " err"}, 32'(v.port ? m1_if.err : m0_if.err), 32'(v.exp_err));
    chk({tag, " resp we"}, 32'(we), 32'd0);
    @(posedge clk); #1;
    chk({tag, " rvalid drop"}, 32'({m1_if.rvalid, m0_if.rvalid}), 32'd0);
    chk({tag, " rdata idle"}, m0_if.rdata | m1_if.rdata, 32'h0);
    idle_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    idle_inputs();
    rst_n = 1'b0;

    // Reset state
    #2;
    chk("rst state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("rst ptr", 32'(dut.ptr_q), 32'd0);
    chk("rst gnt", 32'({m1_if.gnt, m0_if.gnt}), 32'd0);
    chk("rst rvalid", 32'({m1_if.rvalid, m0_if.rvalid}), 32'd0);
    chk("rst err", 32'({m1_if.err, m0_if.err}), 32'd0);
    chk("rst rdata", m0_if.rdata | m1_if.rdata, 32'h0);
    chk("rst we", 32'(we), 32'd0);
    chk("rst daddr", daddr, 32'h0);
    chk("rst dwdata", dwdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    //                 port  we    size  uns   addr         wdata          we     dwdata         rdata          err
    vecs.push_back(mk(1'b0, 1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0,        4'b0000, 32'h0,        32'hDEADBEEF, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, SZ_B, 1'b0, 32'h13, 32'h80,       4'b1000, 32'h80808080, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, SZ_B, 1'b0, 32'h13, 32'h0,        4'b0000, 32'h0,        32'hFFFFFF80, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, SZ_B, 1'b1, 32'h13, 32'h0,        4'b0000, 32'h0,        32'h00000080, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, SZ_H, 1'b0, 32'h22, 32'h1234,     4'b1100, 32'h12341234, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 1'b0, SZ_H, 1'b0, 32'h22, 32'h0,        4'b0000, 32'h0,        32'h00001234, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, SZ_H, 1'b0, 32'h24, 32'hFFFF8001, 4'b0011, 32'h80018001, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, SZ_H, 1'b0, 32'h24, 32'h0,        4'b0000, 32'h0,        32'hFFFF8001, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, SZ_H, 1'b1, 32'h24, 32'h0,        4'b0000, 32'h0,        32'h00008001, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, SZ_B, 1'b1, 32'h12, 32'h0,        4'b0000, 32'h0,        32'h000000AD, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, SZ_B, 1'b0, 32'h12, 32'h0,        4'b0000, 32'h0,        32'hFFFFFFAD, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0,        4'b0000, 32'h0,        32'h80ADBEEF, 1'b0));
    // illegal accesses
    vecs.push_back(mk(1'b0, 1'b1, SZ_W, 1'b0, 32'h06, 32'hFFFFFFFF, 4'b0000, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 1'b1, SZ_H, 1'b0, 32'h21, 32'hFFFF,     4'b0000, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b0, 1'b0, SZ_W, 1'b0, 32'h7E, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 1'b0, SZ_B, 1'b1, 32'h80, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b0, 1'b1, SZ_B, 1'b0, 32'h80, 32'h77,       4'b0000, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 1'b0, SZ_RSV,1'b0,32'h00, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1));
    // top-of-memory boundary, still legal
    vecs.push_back(mk(1'b1, 1'b0, SZ_W, 1'b0, 32'h7C, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b1, SZ_B, 1'b0, 32'h7F, 32'h5A,       4'b1000, 32'h5A5A5A5A, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 1'b0, SZ_B, 1'b1, 32'h7F, 32'h0,        4'b0000, 32'h0,        32'h0000005A, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, SZ_H, 1'b0, 32'h7E, 32'h0,        4'b0000, 32'h0,        32'h00005A00, 1'b0));
    // illegal stores left memory untouched
    vecs.push_back(mk(1'b1, 1'b0, SZ_W, 1'b0, 32'h04, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 1'b0, SZ_H, 1'b1, 32'h20, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0));

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Both requesters continuously: alternating grants every third cycle
    do_reset();
    @(negedge clk);
    drive_port(1'b0, 1'b1, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
    drive_port(1'b1, 1'b1, 1'b0, SZ_W, 1'b0, 32'h7C, 32'h0);
    for (int c = 0; c < 12; c++) begin
      logic e0, e1, r0, r1;
      #1;
      e0 = (c % 3 == 0) && ((c / 3) % 2 == 0);
      e1 = (c % 3 == 0) && ((c / 3) % 2 == 1);
      r0 = (c % 3 == 2) && ((c / 3) % 2 == 0);
      r1 = (c % 3 == 2) && ((c / 3) % 2 == 1);
      chk($sformatf("arb c%0d gnt0", c), 32'(m0_if.gnt), 32'(e0));
      chk($sformatf("arb c%0d gnt1", c), 32'(m1_if.gnt), 32'(e1));
      chk($sformatf("arb c%0d rvalid0", c), 32'(m0_if.rvalid), 32'(r0));
      chk($sformatf("arb c%0d rvalid1", c), 32'(m1_if.rvalid), 32'(r1));
      @(negedge clk);
    end
    idle_inputs();

    // Reset during ACCESS of a word store aborts it
    do_reset();
    @(negedge clk);
    drive_port(1'b0, 1'b1, 1'b1, SZ_W, 1'b0, 32'h20, 32'hCAFEF00D);
    #1;
    chk("abort gnt", 32'(m0_if.gnt), 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    chk("abort access we", 32'(we), 32'hF);
    rst_n = 1'b0;
    #1;
    chk("abort rst we", 32'(we), 32'd0);
    chk("abort rst daddr", daddr, 32'h0);
    chk("abort rst dwdata", dwdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("abort ptr", 32'(dut.ptr_q), 32'd0);
    chk("abort mem 0x20", mem[8], 32'h12340000);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("abort c%0d rvalid", c), 32'({m1_if.rvalid, m0_if.rvalid}), 32'd0);
      @(negedge clk);
    end
    // pointer back at m0: a tie goes to m0
    drive_port(1'b0, 1'b1, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
    drive_port(1'b1, 1'b1, 1'b0, SZ_W, 1'b0, 32'h24, 32'h0);
    #1;
    chk("abort tie gnt0", 32'(m0_if.gnt), 32'd1);
    chk("abort tie gnt1", 32'(m1_if.gnt), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    chk("abort tie rdata", m0_if.rdata, 32'h12340000);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
